tag_sram_arbiter: RTL and testbench

Round-robin arbiter that shares one port of the tag SRAM macro wrapper among `NumReq` independent requesters, such as the AXI read path, AXI write path and tag-cache refill. It grants at most one request per cycle to the SRAM. It tracks each accepted request through the fixed SRAM read latency and returns a response valid, and read data, to the requester that issued it. It sits directly in front of the single-port SRAM instance inside the tag controller.

---
 rtl/tag_sram_pkg.sv | 35 +++
 rtl/tag_sram_rr_arb.sv | 52 +++++
 rtl/tag_sram_arbiter.sv | 90 +++++++++
 tb/tb_tag_sram_arbiter.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tag_sram_pkg.sv
// Shared types and the round-robin search helper for the tag SRAM arbiter.
package tag_sram_pkg;

    // Widest index the helper supports; NumReq must not exceed MaxReq.
    localparam int unsigned MaxIdxWidth = 5;
    localparam int unsigned MaxReq      = 2 ** MaxIdxWidth;

    typedef logic [MaxIdxWidth-1:0] idx_t;

    typedef struct packed {
        logic valid;
        idx_t idx;
    } resp_stage_t;

    // First asserted request at or after prio, wrapping at num_req.
    // Returns prio when nothing is requested; callers gate with |req.
    function automatic idx_t rr_next(input idx_t prio, input logic [MaxReq-1:0] req,
                                     input int unsigned num_req);
        logic        found;
        int unsigned j;
        rr_next = prio;
        found   = 1'b0;
        for (int unsigned i = 0; i < MaxReq; i++) begin
            if (i < num_req && !found) begin
                j = 32'(prio) + i;
                if (j >= num_req) j -= num_req;
                if (req[idx_t'(j)]) begin
                    rr_next = idx_t'(j);
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/tag_sram_rr_arb.sv
// Round-robin arbiter: priority pointer plus wrap-around search, zero-cycle grant.
module tag_sram_rr_arb
    import tag_sram_pkg::*;
#(
    parameter int unsigned NumReq   = 3,
    parameter int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumReq-1:0]   req_i,
    output logic [NumReq-1:0]   gnt_o,
    output logic [IdxWidth-1:0] gnt_idx_o
);

    logic [IdxWidth-1:0] prio_q, prio_d;
    logic [MaxReq-1:0]   req_ext;
    logic                any;
    idx_t                win;

    always_comb begin
        req_ext               = '0;
        req_ext[NumReq-1:0] = req_i;
    end

    // Grants are gated by reset so nothing reaches the SRAM while held.
    assign any       = rst_ni & (|req_i);
    assign win       = rr_next(idx_t'(prio_q), req_ext, NumReq);
    assign gnt_idx_o = IdxWidth'(win);

    always_comb begin
        gnt_o = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            gnt_o[k] = any && (win == idx_t'(k));
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (any) begin
            prio_d = (gnt_idx_o == IdxWidth'(NumReq - 1)) ? '0 : gnt_idx_o + IdxWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= '0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/tag_sram_arbiter.sv
// Shares one tag SRAM port among NumReq requesters and routes each response
// back to its issuer after the fixed SRAM read latency.
module tag_sram_arbiter
    import tag_sram_pkg::*;
#(
    parameter  int unsigned NumReq    = 3,
    parameter  int unsigned NumWords  = 1024,
    parameter  int unsigned DataWidth = 128,
    parameter  int unsigned ByteWidth = 8,
    parameter  int unsigned Latency   = 1,
    localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
    localparam int unsigned IdxWidth  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumReq-1:0]                   req_i,
    input  logic [NumReq-1:0]                   we_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]    addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
    input  logic [NumReq-1:0][BeWidth-1:0]      be_i,
    output logic [NumReq-1:0]                   gnt_o,
    output logic [NumReq-1:0]                   rvalid_o,
    output logic [DataWidth-1:0]                rdata_o,
    output logic                                sram_req_o,
    output logic                                sram_we_o,
    output logic [AddrWidth-1:0]                sram_addr_o,
    output logic [DataWidth-1:0]                sram_wdata_o,
    output logic [BeWidth-1:0]                  sram_be_o,
    input  logic [DataWidth-1:0]                sram_rdata_i
);

    logic [NumReq-1:0]   gnt;
    logic [IdxWidth-1:0] gnt_idx;
    logic                accept;
    resp_stage_t         pipe_q [Latency];

    tag_sram_rr_arb #(
        .NumReq   (NumReq),
        .IdxWidth (IdxWidth)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req_i),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign gnt_o      = gnt;
    assign accept     = |(req_i & gnt);
    assign sram_req_o = accept;
    assign rdata_o    = sram_rdata_i;

    always_comb begin
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (gnt[k]) begin
                sram_we_o    = we_i[k];
                sram_addr_o  = addr_i[k];
                sram_wdata_o = wdata_i[k];
                sram_be_o    = be_i[k];
            end
        end
    end

    // Writes also travel the pipe so every accept gets exactly one rvalid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned s = 0; s < Latency; s++) begin
                pipe_q[s] <= '0;
            end
        end else begin
            pipe_q[0] <= '{valid: accept, idx: idx_t'(gnt_idx)};
            for (int unsigned s = 1; s < Latency; s++) begin
                pipe_q[s] <= pipe_q[s-1];
            end
        end
    end

    always_comb begin
        rvalid_o = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            rvalid_o[k] = pipe_q[Latency-1].valid && (pipe_q[Latency-1].idx == idx_t'(k));
        end
    end

endmodule

// File: tb/tb_tag_sram_arbiter.sv
// Bench for tag_sram_arbiter: three instances (Latency 1..3) share one stimulus
// stream and are checked against a transaction-level arbitration/memory model.
module tb_tag_sram_arbiter;

    localparam int NR = 3;
    localparam int DW = 128;
    localparam int AW = 10;
    localparam int BW = 16;
    localparam int NL = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n;
    logic [NR-1:0]          req, we;
    logic [NR-1:0][AW-1:0]  addr;
    logic [NR-1:0][DW-1:0]  wdata;
    logic [NR-1:0][BW-1:0]  be;

    logic [NR-1:0] gnt_w        [NL];
    logic [NR-1:0] rvalid_w     [NL];
    logic [DW-1:0] rdata_w      [NL];
    logic          sram_req_w   [NL];
    logic          sram_we_w    [NL];
    logic [AW-1:0] sram_addr_w  [NL];
    logic [DW-1:0] sram_wdata_w [NL];
    logic [BW-1:0] sram_be_w    [NL];

    for (genvar li = 0; li < NL; li++) begin : g_dut
        logic [DW-1:0] mem     [1024];
        logic [DW-1:0] rd_pipe [li+1];

        tag_sram_arbiter #(
            .NumReq    (NR),
            .NumWords  (1024),
            .DataWidth (DW),
            .ByteWidth (8),
            .Latency   (li + 1)
        ) u_dut (
            .clk_i        (clk),
            .rst_ni       (rst_n),
            .req_i        (req),
            .we_i         (we),
            .addr_i       (addr),
            .wdata_i      (wdata),
            .be_i         (be),
            .gnt_o        (gnt_w[li]),
            .rvalid_o     (rvalid_w[li]),
            .rdata_o      (rdata_w[li]),
            .sram_req_o   (sram_req_w[li]),
            .sram_we_o    (sram_we_w[li]),
            .sram_addr_o  (sram_addr_w[li]),
            .sram_wdata_o (sram_wdata_w[li]),
            .sram_be_o    (sram_be_w[li]),
            .sram_rdata_i (rd_pipe[li])
        );

        // Simple SRAM macro model with the matching read latency.
        always @(posedge clk) begin
            if (sram_req_w[li] && sram_we_w[li]) begin
                for (int b = 0; b < BW; b++) begin
                    if (sram_be_w[li][b]) mem[sram_addr_w[li]][b*8 +: 8] <= sram_wdata_w[li][b*8 +: 8];
                end
            end else if (sram_req_w[li]) begin
                rd_pipe[0] <= mem[sram_addr_w[li]];
            end
            for (int s = 1; s <= li; s++) rd_pipe[s] <= rd_pipe[s-1];
        end
    end

    // Reference model state
    int            n_cmp = 0;
    int            n_err = 0;
    int            prio;
    int            edge_n = 0;
    logic [DW-1:0] refmem    [1024];
    logic          ev        [NL][8];
    logic [1:0]    ei        [NL][8];
    logic          er        [NL][8];
    logic [DW-1:0] ed        [NL][8];
    logic [NR-1:0] exp_rv    [NL];
    logic          exp_isrd  [NL];
    logic [DW-1:0] exp_rdata [NL];

    function automatic int model_idx();
        if (rst_n !== 1'b1) return -1;
        for (int i = 0; i < NR; i++) begin
            int j;
            j = (prio + i) % NR;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] model_gnt();
        int g;
        g = model_idx();
        return (g < 0) ? 3'b000 : 3'(1 << g);
    endfunction

    task automatic clear_model();
        prio = 0;
        for (int l = 0; l < NL; l++) for (int s = 0; s < 8; s++) ev[l][s] = 1'b0;
    endtask

    task automatic clear_inputs();
        req = '0; we = '0; addr = '0; wdata = '0; be = '0;
    endtask

    // Advance one clock; afterwards exp_* describe the response cycle now visible.
    task automatic tick();
        int g, t;
        logic [1:0] gi;
        g = model_idx();
        @(posedge clk);
        edge_n++;
        if (g >= 0) begin
            gi = 2'(g);
            for (int l = 0; l < NL; l++) begin
                t = (edge_n + l) % 8;
                ev[l][t] = 1'b1;
                ei[l][t] = gi;
                er[l][t] = !we[gi];
                ed[l][t] = refmem[addr[gi]];
            end
            if (we[gi]) begin
                for (int b = 0; b < BW; b++) begin
                    if (be[gi][b]) refmem[addr[gi]][b*8 +: 8] = wdata[gi][b*8 +: 8];
                end
            end
            prio = (g + 1) % NR;
        end
        @(negedge clk);
        t = edge_n % 8;
        for (int l = 0; l < NL; l++) begin
            exp_rv[l]    = ev[l][t] ? 3'(1 << ei[l][t]) : 3'b000;
            exp_isrd[l]  = ev[l][t] && er[l][t];
            exp_rdata[l] = ed[l][t];
            ev[l][t]     = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_model();
        clear_inputs();
        req = 3'b111;
        repeat (2) @(negedge clk);
        #1;
        for (int l = 0; l < NL; l++) begin
            n_cmp += 3;
            if (gnt_w[l] !== 3'b000) begin
                n_err++;
                $display("FAIL reset_gnt lat%0d: got %b expected 000", l + 1, gnt_w[l]);
            end
            if (sram_req_w[l] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_sram_req lat%0d: got %b expected 0", l + 1, sram_req_w[l]);
            end
            if (rvalid_w[l] !== 3'b000) begin
                n_err++;
                $display("FAIL reset_rvalid lat%0d: got %b expected 000", l + 1, rvalid_w[l]);
            end
        end
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        for (int c = 0; c < 6; c++) begin
            clear_inputs();
            if (c == 0) begin
                req = 3'b010; we = 3'b010; addr[1] = 10'd5; wdata[1] = {16{8'hA5}}; be[1] = '1;
            end else if (c == 1) begin
                req = 3'b010; addr[1] = 10'd5;
            end
            #1;
            for (int l = 0; l < NL; l++) begin
                n_cmp++;
                if (gnt_w[l] !== model_gnt()) begin
                    n_err++;
                    $display("FAIL write_read_gnt lat%0d c%0d: got %b expected %b",
                             l + 1, c, gnt_w[l], model_gnt());
                end
            end
            if (c == 0) begin
                n_cmp++;
                if ({sram_req_w[0], sram_we_w[0], sram_addr_w[0], sram_be_w[0], sram_wdata_w[0]} !==
                    {1'b1, 1'b1, 10'd5, 16'hFFFF, {16{8'hA5}}}) begin
                    n_err++;
                    $display("FAIL write_read_sram: got req=%b we=%b addr=%0d be=%h wdata=%h",
                             sram_req_w[0], sram_we_w[0], sram_addr_w[0], sram_be_w[0], sram_wdata_w[0]);
                end
            end
            tick();
            for (int l = 0; l < NL; l++) begin
                n_cmp++;
                if (rvalid_w[l] !== exp_rv[l]) begin
                    n_err++;
                    $display("FAIL write_read_rvalid lat%0d c%0d: got %b expected %b",
                             l + 1, c, rvalid_w[l], exp_rv[l]);
                end
                if (exp_isrd[l]) begin
                    n_cmp++;
                    if (rdata_w[l] !== exp_rdata[l]) begin
                        n_err++;
                        $display("FAIL write_read_rdata lat%0d: got %h expected %h",
                                 l + 1, rdata_w[l], exp_rdata[l]);
                    end
                end
            end
        end
    endtask

    task automatic test_fairness();
        for (int c = 0; c < 9; c++) begin
            clear_inputs();
            if (c < 6) begin
                req = 3'b111; addr[0] = 10'd5; addr[1] = 10'd5; addr[2] = 10'd5;
            end
            #1;
            for (int l = 0; l < NL; l++) begin
                n_cmp++;
                if (gnt_w[l] !== model_gnt()) begin
                    n_err++;
                    $display("FAIL fairness_gnt lat%0d c%0d: got %b expected %b",
                             l + 1, c, gnt_w[l], model_gnt());
                end
            end
            tick();
            for (int l = 0; l < NL; l++) begin
                n_cmp++;
                if (rvalid_w[l] !== exp_rv[l]) begin
                    n_err++;
                    $display("FAIL fairness_rvalid lat%0d c%0d: got %b expected %b",
                             l + 1, c, rvalid_w[l], exp_rv[l]);
                end
            end
        end
    endtask

    task automatic test_wrap_skip();
        logic [NR-1:0] lit [4];
        lit = '{3'b010, 3'b001, 3'b010, 3'b001};
        for (int c = 0; c < 7; c++) begin
            clear_inputs();
            addr[0] = 10'd5; addr[1] = 10'd5;
            if (c == 0) req = 3'b010;
            else if (c < 4) req = 3'b011;
            #1;
            for (int l = 0; l < NL; l++) begin
                n_cmp++;
                if (gnt_w[l] !== model_gnt()) begin
                    n_err++;
                    $display("FAIL wrap_gnt lat%0d c%0d: got %b expected %b",
                             l + 1, c, gnt_w[l], model_gnt());
                end
            end
            if (c < 4) begin
                n_cmp++;
                if (gnt_w[0] !== lit[c]) begin
                    n_err++;
                    $display("FAIL wrap_seq c%0d: got %b expected %b", c, gnt_w[0], lit[c]);
                end
            end
            tick();
            for (int l = 0; l < NL; l++) begin
                n_cmp++;
                if (rvalid_w[l] !== exp_rv[l]) begin
                    n_err++;
                    $display("FAIL wrap_rvalid lat%0d c%0d: got %b expected %b",
                             l + 1, c, rvalid_w[l], exp_rv[l]);
                end
            end
        end
    endtask

    task automatic test_latency();
        logic [NR-1:0] lit [3];
        lit = '{3'b001, 3'b100, 3'b010};
        for (int c = 0; c < 10; c++) begin
            clear_inputs();
            if (c < 3) begin
                req = 3'b001; we = 3'b001; addr[0] = 10'(c + 1);
                wdata[0] = {$urandom(), $urandom(), $urandom(), $urandom()}; be[0] = '1;
            end else if (c == 3) begin
                req = 3'b001; addr[0] = 10'd1;
            end else if (c == 4) begin
                req = 3'b100; addr[2] = 10'd2;
            end else if (c == 5) begin
                req = 3'b010; addr[1] = 10'd3;
            end
            #1;
            for (int l = 0; l < NL; l++) begin
                n_cmp++;
                if (gnt_w[l] !== model_gnt()) begin
                    n_err++;
                    $display("FAIL latency_gnt lat%0d c%0d: got %b expected %b",
                             l + 1, c, gnt_w[l], model_gnt());
                end
            end
            tick();
            for (int l = 0; l < NL; l++) begin
                n_cmp++;
                if (rvalid_w[l] !== exp_rv[l]) begin
                    n_err++;
                    $display("FAIL latency_rvalid lat%0d c%0d: got %b expected %b",
                             l + 1, c, rvalid_w[l], exp_rv[l]);
                end
                if (exp_isrd[l]) begin
                    n_cmp++;
                    if (rdata_w[l] !== exp_rdata[l]) begin
                        n_err++;
                        $display("FAIL latency_rdata lat%0d c%0d: got %h expected %h",
                                 l + 1, c, rdata_w[l], exp_rdata[l]);
                    end
                end
            end
            // Latency-3 instance: reads issued in cycles 3,4,5 return in cycles 6,7,8.
            if (c >= 5 && c <= 7) begin
                n_cmp++;
                if (rvalid_w[2] !== lit[c-5]) begin
                    n_err++;
                    $display("FAIL latency3_seq c%0d: got %b expected %b", c, rvalid_w[2], lit[c-5]);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        int g;
        for (int c = 0; c < 10; c++) begin
            clear_inputs();
            if (c == 0) begin
                req = 3'b001; addr[0] = 10'd1;
            end else if (c == 1) begin
                rst_n = 1'b0;
                clear_model();
            end else if (c == 3) begin
                rst_n = 1'b1;
            end
            if (c >= 3 && c < 5) begin
                req = 3'b110; addr[1] = 10'd5; addr[2] = 10'd2;
                if (c == 4) req = 3'b100;
            end
            #1;
            for (int l = 0; l < NL; l++) begin
                n_cmp++;
                if (gnt_w[l] !== model_gnt()) begin
                    n_err++;
                    $display("FAIL midreset_gnt lat%0d c%0d: got %b expected %b",
                             l + 1, c, gnt_w[l], model_gnt());
                end
            end
            if (c == 3) begin
                n_cmp++;
                if (gnt_w[0] !== 3'b010) begin
                    n_err++;
                    $display("FAIL midreset_first_gnt: got %b expected 010", gnt_w[0]);
                end
            end
            g = model_idx();
            tick();
            for (int l = 0; l < NL; l++) begin
                n_cmp++;
                if (rvalid_w[l] !== exp_rv[l]) begin
                    n_err++;
                    $display("FAIL midreset_rvalid lat%0d c%0d: got %b expected %b",
                             l + 1, c, rvalid_w[l], exp_rv[l]);
                end
            end
            if (c == 2) begin
                n_cmp++;
                if (g != -1) begin
                    n_err++;
                    $display("FAIL midreset_model_idle: got %0d expected -1", g);
                end
            end
        end
    endtask

    task automatic test_random();
        int g;
        logic [1:0] gi;
        logic [1+1+AW+BW+DW-1:0] exp_sram;
        clear_inputs();
        for (int c = 0; c < 420; c++) begin
            if (c < 16) begin
                clear_inputs();
                gi = 2'(c % NR);
                req[gi] = 1'b1; we[gi] = 1'b1; addr[gi] = 10'(c); be[gi] = '1;
                wdata[gi] = {$urandom(), $urandom(), $urandom(), $urandom()};
            end else if (c < 410) begin
                for (int k = 0; k < NR; k++) begin
                    if (!req[k] && $urandom_range(0, 1) == 1) begin
                        req[k]   = 1'b1;
                        we[k]    = 1'($urandom_range(0, 1));
                        addr[k]  = 10'($urandom_range(0, 15));
                        wdata[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
                        be[k]    = 16'($urandom());
                    end
                end
            end else begin
                clear_inputs();
            end
            #1;
            g = model_idx();
            for (int l = 0; l < NL; l++) begin
                n_cmp++;
                if (gnt_w[l] !== model_gnt()) begin
                    n_err++;
                    $display("FAIL random_gnt lat%0d c%0d: got %b expected %b",
                             l + 1, c, gnt_w[l], model_gnt());
                end
            end
            if (g >= 0) begin
                gi = 2'(g);
                exp_sram = {1'b1, we[gi], addr[gi], be[gi], wdata[gi]};
            end else begin
                exp_sram = '0;
            end
            n_cmp++;
            if ({sram_req_w[0], sram_we_w[0], sram_addr_w[0], sram_be_w[0], sram_wdata_w[0]}
                !== exp_sram) begin
                n_err++;
                $display("FAIL random_sram c%0d: got %h expected %h", c,
                         {sram_req_w[0], sram_we_w[0], sram_addr_w[0], sram_be_w[0], sram_wdata_w[0]},
                         exp_sram);
            end
            tick();
            if (g >= 0) req[2'(g)] = 1'b0;
            for (int l = 0; l < NL; l++) begin
                n_cmp++;
                if (rvalid_w[l] !== exp_rv[l]) begin
                    n_err++;
                    $display("FAIL random_rvalid lat%0d c%0d: got %b expected %b",
                             l + 1, c, rvalid_w[l], exp_rv[l]);
                end
                if (exp_isrd[l]) begin
                    n_cmp++;
                    if (rdata_w[l] !== exp_rdata[l]) begin
                        n_err++;
                        $display("FAIL random_rdata lat%0d c%0d: got %h expected %h",
                                 l + 1, c, rdata_w[l], exp_rdata[l]);
                    end
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        clear_model();
        test_reset();
        test_write_read();
        test_fairness();
        test_wrap_skip();
        test_latency();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
